share_random_source: RTL and testbench
======================================

SHARE_RANDOM_SOURCE -- requirements
Module: share_random_source

Interface
REQ-001 Parameter OUT_WIDTH, default 4, SHALL set the number of fresh random bits delivered per transfer; legal range 1..64, elaboration error otherwise.
REQ-002 Parameter WARMUP_CYCLES, default 16, SHALL set the number of discarded LFSR advances after each seed load; legal range 0..255.
REQ-003 in_clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 in_reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_seed  input  32  SHALL carry one seed word.
REQ-006 in_seed_valid  input  1  SHALL qualify in_seed.
REQ-007 out_seed_ready  output  1  SHALL indicate a seed word is accepted this cycle when in_seed_valid is also high.
REQ-008 out_random  output  OUT_WIDTH  SHALL carry the random word, intended to feed the in_random port of the zero-sharing block (NUM_NEEDED*BIT_WIDTH = OUT_WIDTH).
REQ-009 out_valid  output  1  SHALL indicate out_random is valid.
REQ-010 in_ready  input  1  SHALL indicate the consumer takes out_random this cycle when out_valid is high.

Function
REQ-011 The block SHALL hold a 64-bit LFSR state S; one step SHALL be S <= {S[62:0], S[63]^S[62]^S[60]^S[59]}.
REQ-012 One advance SHALL be OUT_WIDTH consecutive steps, unrolled combinationally within one cycle.
REQ-013 out_random SHALL equal S[OUT_WIDTH-1:0] directly from the state register (no combinational path from any input).
REQ-014 FSM states SHALL be UNSEEDED, SEED_HI, WARMUP, RUN; reset state UNSEEDED.
REQ-015 out_seed_ready SHALL be 1 in UNSEEDED, SEED_HI and RUN, and 0 in WARMUP.
REQ-016 UNSEEDED or RUN with in_seed_valid=1: S[31:0] <= in_seed, go to SEED_HI; out_valid drops to 0 the following cycle.
REQ-017 SEED_HI with in_seed_valid=1: S[63:32] <= in_seed; if the complete 64-bit seed is zero, S <= 64'h1; go to WARMUP with warm-up counter cleared, or directly to RUN if WARMUP_CYCLES = 0.
REQ-018 SEED_HI with in_seed_valid=0 SHALL hold state and S indefinitely.
REQ-019 WARMUP SHALL advance S (REQ-012) every cycle and increment an 8-bit counter; after WARMUP_CYCLES advances go to RUN.
REQ-020 out_valid SHALL be 1 only in RUN.
REQ-021 RUN: S SHALL advance exactly when out_valid && in_ready, and hold otherwise (out_random stable while stalled).
REQ-022 RUN with in_seed_valid=1 in the same cycle as in_ready=1: the seed SHALL take priority; that transfer completes with the current out_random, S[31:0] is overwritten, no advance occurs.
REQ-023 S SHALL never become all-zero; an all-zero S reachable only by seeding SHALL be replaced per REQ-017.
REQ-024 Latency: first out_valid SHALL assert WARMUP_CYCLES+1 cycles after the cycle the high seed word is accepted.

Reset
REQ-025 With in_reset=1 at a clock edge: state <= UNSEEDED, S <= 64'h0, warm-up counter <= 0, out_valid = 0, out_random = 0, out_seed_ready = 1 the following cycle.
REQ-026 Reset SHALL take priority over all other inputs, including reset asserted mid-seed or mid-warm-up; a full two-word seed SHALL be required afterwards.
REQ-027 Outputs SHALL be defined (no X) from the first cycle after reset.

Verification (OUT_WIDTH=8, WARMUP_CYCLES=0 unless noted)
REQ-028 Reset, no seed for 20 cycles -> out_valid=0, out_random=0x00, out_seed_ready=1 throughout.
REQ-029 Seed words 0x00000000, 0x00000000 -> next cycle out_valid=1, out_random=0x01; one cycle in_ready=1 -> out_random=0x00 (S=0x100).
REQ-030 Seed 0x000000A5 then 0x00000000, in_ready=0 for 10 cycles -> out_random stays 0xA5, out_valid stays 1.
REQ-031 WARMUP_CYCLES=3, any seed -> out_seed_ready=0 and out_valid=0 for exactly 3 cycles, out_valid=1 on the 4th; out_random matches a reference model of 3 advances.
REQ-032 In RUN, assert in_seed_valid with in_ready=1 -> out_valid=0 next cycle, S[31:0] = new word, resume after high word with no extra transfer counted.
REQ-033 Assert in_reset during WARMUP and during SEED_HI -> UNSEEDED next cycle, out_valid=0, out_random=0x00.

Source files
------------

// File: rtl/share_random_source.sv
// Seeded 64-bit LFSR random source feeding a zero-sharing block.
// Two-word seed load, optional warm-up discard, then ready/valid delivery.
module share_random_source #(
   parameter int unsigned OUT_WIDTH     = 4,
   parameter int unsigned WARMUP_CYCLES = 16
) (
   input  logic                 in_clock,
   input  logic                 in_reset,
   input  logic [31:0]          in_seed,
   input  logic                 in_seed_valid,
   output logic                 out_seed_ready,
   output logic [OUT_WIDTH-1:0] out_random,
   output logic                 out_valid,
   input  logic                 in_ready
);

   localparam int unsigned STATE_W = 64;
   localparam int unsigned SEED_W  = 32;
   localparam int unsigned CNT_W   = 8;
   localparam logic [CNT_W-1:0] WARM_LAST =
      CNT_W'((WARMUP_CYCLES == 0) ? 0 : (WARMUP_CYCLES - 1));

   if ((OUT_WIDTH < 1) || (OUT_WIDTH > 64)) begin : g_bad_out_width
      $error("share_random_source: OUT_WIDTH must be in 1..64");
   end
   if (WARMUP_CYCLES > 255) begin : g_bad_warmup
      $error("share_random_source: WARMUP_CYCLES must be in 0..255");
   end

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      SEED_HI  = 2'd1,
      WARMUP   = 2'd2,
      RUN      = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [STATE_W-1:0]   lfsr_q, lfsr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic                 seed_ready_q, seed_ready_d;
   logic [STATE_W-1:0]   seed_full;

   // One advance = OUT_WIDTH single steps, unrolled within the cycle
   function automatic logic [STATE_W-1:0] lfsr_advance(input logic [STATE_W-1:0] s);
      logic [STATE_W-1:0] t;
      t = s;
      for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
         t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
      end
      return t;
   endfunction

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      cnt_d        = cnt_q;
      seed_full    = {in_seed, lfsr_q[SEED_W-1:0]};

      case (state_q)
         UNSEEDED: begin
            if (in_seed_valid) begin
               lfsr_d[SEED_W-1:0] = in_seed;
               state_d            = SEED_HI;
            end
         end
         SEED_HI: begin
            if (in_seed_valid) begin
               // An all-zero seed would lock the LFSR; substitute 1
               lfsr_d  = (seed_full == '0) ? STATE_W'(1) : seed_full;
               cnt_d   = '0;
               state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
            end
         end
         WARMUP: begin
            lfsr_d = lfsr_advance(lfsr_q);
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == WARM_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // A new seed wins over a simultaneous transfer; no advance then
            if (in_seed_valid) begin
               lfsr_d[SEED_W-1:0] = in_seed;
               state_d            = SEED_HI;
            end else if (in_ready) begin
               lfsr_d = lfsr_advance(lfsr_q);
            end
         end
         default: begin
            state_d = UNSEEDED;
         end
      endcase

      valid_d      = (state_d == RUN);
      seed_ready_d = (state_d != WARMUP);
   end

   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         state_q      <= UNSEEDED;
         lfsr_q       <= '0;
         cnt_q        <= '0;
         valid_q      <= 1'b0;
         seed_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         seed_ready_q <= seed_ready_d;
      end
   end

   assign out_random     = lfsr_q[OUT_WIDTH-1:0];
   assign out_valid      = valid_q;
   assign out_seed_ready = seed_ready_q;

endmodule

// File: tb/tb_share_random_source.sv
// Directed bench for share_random_source: one instance without warm-up,
// one with a 3-cycle warm-up, both at OUT_WIDTH=8.
module tb_share_random_source;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        r0, sv0, rdy0, sr0, v0;
   logic [31:0] seed0;
   logic [7:0]  rnd0;
   logic        r3, sv3, rdy3, sr3, v3;
   logic [31:0] seed3;
   logic [7:0]  rnd3;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_s;

   share_random_source #(.OUT_WIDTH(8), .WARMUP_CYCLES(0)) dut0 (
      .in_clock(clk), .in_reset(r0), .in_seed(seed0), .in_seed_valid(sv0),
      .out_seed_ready(sr0), .out_random(rnd0), .out_valid(v0), .in_ready(rdy0));

   share_random_source #(.OUT_WIDTH(8), .WARMUP_CYCLES(3)) dut3 (
      .in_clock(clk), .in_reset(r3), .in_seed(seed3), .in_seed_valid(sv3),
      .out_seed_ready(sr3), .out_random(rnd3), .out_valid(v3), .in_ready(rdy3));

   function automatic logic [63:0] adv8(input logic [63:0] s);
      logic [63:0] t;
      t = s;
      for (int i = 0; i < 8; i++) t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      r0 = 1; r3 = 1; tick(); r0 = 0; r3 = 0;
      for (int i = 0; i < 20; i++) begin
         total++;
         if ({v0, rnd0, sr0} !== {1'b0, 8'h00, 1'b1}) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got v=%b r=%h sr=%b want v=0 r=00 sr=1", i, v0, rnd0, sr0);
         end
         total++;
         if ({v3, rnd3, sr3} !== {1'b0, 8'h00, 1'b1}) begin
            bad++;
            $display("FAIL reset_idle_w3 cyc=%0d got v=%b r=%h sr=%b want v=0 r=00 sr=1", i, v3, rnd3, sr3);
         end
         tick();
      end
   endtask

   task automatic test_zero_seed();
      sv0 = 1; seed0 = 32'h0; tick();
      total++;
      if ({v0, sr0} !== 2'b01) begin
         bad++; $display("FAIL zero_seed_hi got v=%b sr=%b want v=0 sr=1", v0, sr0);
      end
      tick(); sv0 = 0;
      total++;
      if ({v0, rnd0} !== {1'b1, 8'h01}) begin
         bad++; $display("FAIL zero_seed_run got v=%b r=%h want v=1 r=01", v0, rnd0);
      end
      rdy0 = 1; tick(); rdy0 = 0;
      total++;
      if ({v0, rnd0} !== {1'b1, 8'h00}) begin
         bad++; $display("FAIL zero_seed_adv got v=%b r=%h want v=1 r=00", v0, rnd0);
      end
   endtask

   task automatic test_stall();
      sv0 = 1; seed0 = 32'h0000_00A5; tick();
      seed0 = 32'h0; tick(); sv0 = 0;
      for (int i = 0; i < 10; i++) begin
         total++;
         if ({v0, rnd0} !== {1'b1, 8'hA5}) begin
            bad++; $display("FAIL stall cyc=%0d got v=%b r=%h want v=1 r=a5", i, v0, rnd0);
         end
         tick();
      end
   endtask

   task automatic test_seed_priority();
      sv0 = 1; rdy0 = 1; seed0 = 32'h0000_003C; tick();
      total++;
      if ({v0, rnd0, sr0} !== {1'b0, 8'h3C, 1'b1}) begin
         bad++; $display("FAIL prio_lo got v=%b r=%h sr=%b want v=0 r=3c sr=1", v0, rnd0, sr0);
      end
      rdy0 = 0; seed0 = 32'h8000_0000; tick(); sv0 = 0;
      total++;
      if ({v0, rnd0} !== {1'b1, 8'h3C}) begin
         bad++; $display("FAIL prio_hi got v=%b r=%h want v=1 r=3c", v0, rnd0);
      end
      rdy0 = 1; tick();
      total++;
      if (rnd0 !== 8'h80) begin
         bad++; $display("FAIL prio_first_adv got r=%h want r=80", rnd0);
      end
   endtask

   task automatic test_back_to_back();
      exp_s = 64'h0000_0000_0000_3C80;
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_s = adv8(exp_s);
         total++;
         if ({v0, rnd0} !== {1'b1, exp_s[7:0]}) begin
            bad++; $display("FAIL b2b cyc=%0d got v=%b r=%h want v=1 r=%h", i, v0, rnd0, exp_s[7:0]);
         end
      end
      rdy0 = 0;
   endtask

   task automatic test_nonzero_seed();
      r0 = 1; tick(); r0 = 0;
      sv0 = 1; seed0 = 32'h0000_00A5; tick();
      seed0 = 32'h8000_0000; tick(); sv0 = 0;
      rdy0 = 1; tick(); rdy0 = 0;
      total++;
      if (rnd0 !== 8'h80) begin
         bad++; $display("FAIL feedback_adv got r=%h want r=80", rnd0);
      end
   endtask

   task automatic test_warmup();
      sv3 = 1; seed3 = 32'h1234_5678; tick();
      seed3 = 32'hDEAD_BEEF; tick(); sv3 = 0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({v3, sr3} !== 2'b00) begin
            bad++; $display("FAIL warmup cyc=%0d got v=%b sr=%b want v=0 sr=0", i, v3, sr3);
         end
         tick();
      end
      exp_s = adv8(adv8(adv8(64'hDEAD_BEEF_1234_5678)));
      total++;
      if ({v3, sr3, rnd3} !== {1'b1, 1'b1, exp_s[7:0]}) begin
         bad++; $display("FAIL warmup_done got v=%b sr=%b r=%h want v=1 sr=1 r=%h", v3, sr3, rnd3, exp_s[7:0]);
      end
      rdy3 = 1; tick(); rdy3 = 0;
      exp_s = adv8(exp_s);
      total++;
      if (rnd3 !== exp_s[7:0]) begin
         bad++; $display("FAIL warmup_xfer got r=%h want r=%h", rnd3, exp_s[7:0]);
      end
   endtask

   task automatic test_reset_mid();
      sv3 = 1; seed3 = 32'h0000_0001; tick();
      seed3 = 32'h0000_0002; tick(); sv3 = 0;
      r3 = 1; tick(); r3 = 0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({v3, rnd3, sr3} !== {1'b0, 8'h00, 1'b1}) begin
            bad++; $display("FAIL reset_warmup cyc=%0d got v=%b r=%h sr=%b want v=0 r=00 sr=1", i, v3, rnd3, sr3);
         end
         tick();
      end
      sv0 = 1; seed0 = 32'h0000_0011; tick(); sv0 = 0;
      r0 = 1; tick(); r0 = 0;
      total++;
      if ({v0, rnd0, sr0} !== {1'b0, 8'h00, 1'b1}) begin
         bad++; $display("FAIL reset_seed_hi got v=%b r=%h sr=%b want v=0 r=00 sr=1", v0, rnd0, sr0);
      end
      sv0 = 1; seed0 = 32'h0000_0022; tick(); sv0 = 0; tick();
      total++;
      if ({v0, rnd0} !== {1'b0, 8'h22}) begin
         bad++; $display("FAIL needs_hi_word got v=%b r=%h want v=0 r=22", v0, rnd0);
      end
      sv0 = 1; seed0 = 32'h0; tick(); sv0 = 0;
      total++;
      if ({v0, rnd0} !== {1'b1, 8'h22}) begin
         bad++; $display("FAIL reseed_run got v=%b r=%h want v=1 r=22", v0, rnd0);
      end
   endtask

   initial begin
      r0 = 1; sv0 = 0; rdy0 = 0; seed0 = '0;
      r3 = 1; sv3 = 0; rdy3 = 0; seed3 = '0;
      test_reset();
      test_zero_seed();
      test_stall();
      test_seed_priority();
      test_back_to_back();
      test_nonzero_seed();
      test_warmup();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
